// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative RV32M multiply/divide unit
package muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] ITER_LAST = 6'd31;

  function automatic logic op1_signed(input logic [2:0] f);
    return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
           (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f);
    return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add / restoring shift-subtract iteration
// Divide mode exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic        mode_div,
`endif
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        borrow;
`endif

  always_comb begin
    // multiply: {hi,lo} is the accumulator, lo starts as the multiplier
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    hi_nxt = sum[32:1];
    lo_nxt = {sum[0], lo[31:1]};
`ifdef MULDIV_DIV_EN
    // divide: hi is the partial remainder, lo shifts dividend out and quotient in
    shifted = {hi, lo[31]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    borrow  = diff[33];
    if (mode_div) begin
      hi_nxt = borrow ? shifted[31:0] : diff[31:0];
      lo_nxt = {lo[30:0], ~borrow};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit feeding the register file
// Divider and its special cases are built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_op1,
  input  logic [31:0] I_op2,
  input  logic [3:0]  I_rd,
  output logic        O_busy,
  output logic        O_done,
  output logic [31:0] O_result,
  output logic [3:0]  O_rd,
  output logic        O_regwen
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic        neg_q;
  logic        special_q;
  logic [31:0] hi_q, lo_q, opnd_q;
  logic [31:0] hi_nxt, lo_nxt;

  logic        accept;
  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic        div_mode;
  logic        special;
  logic [31:0] special_val;
  logic [63:0] prod;
  logic [31:0] res_fix;
`ifdef MULDIV_DIV_EN
  logic        ovf;
  logic [31:0] qr;
`endif

  assign accept   = (state_q == ST_IDLE) && I_start && !O_done;
  assign O_busy   = (state_q != ST_IDLE) || O_done;
  assign O_regwen = O_done && (O_rd != 4'd0);

  always_comb begin
    s1   = op1_signed(I_funct3) & I_op1[31];
    s2   = op2_signed(I_funct3) & I_op2[31];
    mag1 = s1 ? -I_op1 : I_op1;
    mag2 = s2 ? -I_op2 : I_op2;
`ifdef MULDIV_DIV_EN
    div_mode    = I_funct3[2];
    ovf         = ((I_funct3 == FUNCT3_DIV) || (I_funct3 == FUNCT3_REM)) &&
                  (I_op1 == 32'h8000_0000) && (I_op2 == 32'hFFFF_FFFF);
    special     = I_funct3[2] && ((I_op2 == 32'd0) || ovf);
    if (I_op2 == 32'd0)
      special_val = I_funct3[1] ? I_op1 : 32'hFFFF_FFFF;
    else
      special_val = I_funct3[1] ? 32'd0 : 32'h8000_0000;
`else
    div_mode    = 1'b0;
    special     = I_funct3[2];
    special_val = 32'd0;
`endif
  end

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .mode_div (funct3_q[2]),
`endif
    .hi       (hi_q),
    .lo       (lo_q),
    .opnd     (opnd_q),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  // sign fix-up from the settled accumulator, registered into O_result on leaving DONE
  always_comb begin
    prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    res_fix = (funct3_q == FUNCT3_MUL) ? prod[31:0] : prod[63:32];
`ifdef MULDIV_DIV_EN
    qr = funct3_q[1] ? hi_q : lo_q;
    if (funct3_q[2])
      res_fix = neg_q ? -qr : qr;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == ITER_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      funct3_q  <= 3'd0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      opnd_q    <= 32'd0;
      O_done    <= 1'b0;
      O_result  <= 32'd0;
      O_rd      <= 4'd0;
    end else begin
      state_q <= state_d;
      O_done  <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            funct3_q  <= I_funct3;
            O_rd      <= I_rd;
            cnt_q     <= 6'd0;
            special_q <= special;
            // remainder takes the dividend's sign; everything else the XOR
            neg_q     <= (I_funct3[2] && I_funct3[1]) ? s1 : (s1 ^ s2);
            hi_q      <= special ? special_val : 32'd0;
            lo_q      <= div_mode ? mag1 : mag2;
            opnd_q    <= div_mode ? mag2 : mag1;
          end
        end
        ST_RUN: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q + 6'd1;
        end
        ST_DONE: O_result <= special_q ? hi_q : res_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit (MULDIV_DIV_EN aware)
module tb_muldiv_unit;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_start = 1'b0;
  logic [2:0]  I_funct3 = 3'd0;
  logic [31:0] I_op1 = 32'd0;
  logic [31:0] I_op2 = 32'd0;
  logic [3:0]  I_rd = 4'd0;
  logic        O_busy, O_done, O_regwen;
  logic [31:0] O_result;
  logic [3:0]  O_rd;

  int checks = 0;
  int failures = 0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit dut (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .I_start  (I_start),
    .I_funct3 (I_funct3),
    .I_op1    (I_op1),
    .I_op2    (I_op2),
    .I_rd     (I_rd),
    .O_busy   (O_busy),
    .O_done   (O_done),
    .O_result (O_result),
    .O_rd     (O_rd),
    .O_regwen (O_regwen)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // issues one op; poke_at > 0 re-asserts I_start at that cycle of the op
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int poke_at);
    int lat;
    int extra;
    bit seen;
    I_funct3 = f; I_op1 = a; I_op2 = b; I_rd = rd; I_start = 1'b1;
    @(posedge I_clk); #1;
    I_start = 1'b0; I_op1 = 32'hDEAD_BEEF; I_op2 = 32'h1234_5678; I_rd = 4'hA;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      if (poke_at > 0 && lat == poke_at) begin
        I_start = 1'b1; I_funct3 = 3'd0; I_op1 = 32'd1; I_op2 = 32'd1; I_rd = 4'd9;
      end
      @(posedge I_clk); #1;
      I_start = 1'b0;
      lat++;
      if (lat == 1) check({tag, "_busy_early"}, O_busy, 1);
      if (O_done) seen = 1;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, O_result, exp_res);
    check({tag, "_rd"}, O_rd, rd);
    check({tag, "_regwen"}, O_regwen, (rd != 4'd0));
    @(posedge I_clk); #1;
    check({tag, "_done_fall"}, O_done, 0);
    check({tag, "_res_hold"}, O_result, exp_res);
    if (poke_at > 0) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge I_clk); #1;
        if (O_done) extra++;
      end
      check({tag, "_no_second_done"}, extra, 0);
    end
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge I_clk);
    #1;
    check("rst_busy", O_busy, 0);
    check("rst_done", O_done, 0);
    check("rst_regwen", O_regwen, 0);
    check("rst_result", O_result, 0);
    check("rst_rd", O_rd, 0);
    I_rst = 1'b0;
    @(posedge I_clk); #1;

    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB, 33, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE, 33, 0);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'h0000_0000, 33, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         4'd3, 32'hFFFF_FFFF, 33, 0);

    run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 4'd4, DIV_EN ? 32'hFFFF_FFFD : 32'd0, DIV_EN ? 33 : 1, 0);
    run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 4'd6, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 33 : 1, 0);
    run_op("divu", 3'd5, 32'd100,       32'd7, 4'd7, DIV_EN ? 32'd14 : 32'd0,        DIV_EN ? 33 : 1, 0);
    run_op("remu", 3'd7, 32'd100,       32'd7, 4'd8, DIV_EN ? 32'd2 : 32'd0,         DIV_EN ? 33 : 1, 0);

    run_op("divu_z", 3'd5, 32'd5, 32'd0, 4'd9,  DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1, 0);
    run_op("remu_z", 3'd7, 32'd5, 32'd0, 4'd10, DIV_EN ? 32'd5 : 32'd0,         1, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, DIV_EN ? 32'h8000_0000 : 32'd0, 1, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'd0, 1, 0);

    run_op("poke", 3'd0, 32'd6, 32'd9, 4'd13, 32'd54, 33, 10);

    // abort by reset in the middle of an op
    I_funct3 = 3'd0; I_op1 = 32'd5; I_op2 = 32'd5; I_rd = 4'd14; I_start = 1'b1;
    @(posedge I_clk); #1;
    I_start = 1'b0;
    repeat (10) @(posedge I_clk);
    #1;
    check("abort_busy_before", O_busy, 1);
    I_rst = 1'b1;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    check("abort_busy", O_busy, 0);
    check("abort_done", O_done, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge I_clk); #1;
      if (O_done) dones++;
    end
    check("abort_no_done", dones, 0);

    run_op("rd0", 3'd0, 32'd3, 32'd4, 4'd0, 32'h0000_000C, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
